scope_trace_display: RTL and testbench
======================================

# scope_trace_display

Oscilloscope back end: accepts the stream of 8-bit screen-scaled samples produced by the key/scaling stage (`vga_data`) and renders it on a 640x480@60 Hz VGA monitor. Samples are captured on a rising-edge trigger into a ping-pong trace buffer. The front buffer is read back column-by-column during the raster scan, and the trace is drawn over a 10x10 graticule. The block is both the reader of the scaled-sample stream and the VGA timing master.

## Interface
Parameters:
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing, in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing, in lines.
- `Y_OFF` 112: first raster row of the 256-row trace window.
- `TIMEOUT` 65536: number of valid samples without a trigger before auto-trigger.

Ports:
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sample_in` in 8: scaled sample; 0 = bottom of window, 255 = top.
- `sample_vld` in 1: one-cycle strobe qualifying `sample_in`.
- `trig_level` in 8: trigger threshold.
- `hold` in 1: 1 = freeze the display (buffer swaps inhibited).
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `rgb` out 3: {R,G,B}, one bit per colour.
- `busy` out 1: high while the FSM is in CAPTURE or DONE.
- `auto_trig` out 1: sticky; 1 if the last capture was forced by timeout.

## Operation
- Pixel enable `pix_en` toggles every clk, giving 25 MHz. All raster logic advances only on `pix_en`.
- `h_cnt` runs 0..799 and wraps. `v_cnt` runs 0..524 and increments when `h_cnt` wraps.
- Sync pulses:
  - hsync is low for `h_cnt` in [656,751].
  - vsync is low for `v_cnt` in [490,491].
- Trace buffers: two 640x8 arrays. `front_sel` selects the display buffer; the capture buffer is `!front_sel`.
- Capture FSM (advances on `sample_vld` unless noted):
  - ARM: the first valid sample loads `prev` and the FSM moves to WAIT_TRIG. The timeout counter is cleared.
  - WAIT_TRIG: on each valid sample, the timeout counter increments.
    - Trigger when `prev < trig_level && sample_in >= trig_level`; set `auto_trig` = 0.
    - Otherwise, when the counter reaches `TIMEOUT-1`, force a trigger; set `auto_trig` = 1.
    - In both cases the triggering sample is written to address 0, `wr_addr` = 1, and the FSM moves to CAPTURE.
    - `prev` is updated on every valid sample.
  - CAPTURE: write each valid sample at `wr_addr` and increment. After the write at address 639, move to DONE. Further samples are ignored.
  - DONE: wait for the swap point. The swap point is the `pix_en` cycle where `h_cnt`=0 and `v_cnt`=480, i.e. the start of vertical blank.
    - At the swap point with `hold`=0: toggle `front_sel` and go to ARM in the same cycle.
    - With `hold`=1: stay in DONE. The swap occurs at the first swap point after `hold` falls.
- A trigger and a timeout on the same sample count as a true trigger (`auto_trig` = 0).
- Capture writes never touch the front buffer, so there is no read/write conflict.
- Pixel rendering, in the active area only (`h_cnt` < 640, `v_cnt` < 480; elsewhere `rgb` = 0):
  - Trace row for column x: `Y_OFF + (255 - front[x])`. The subtraction is 8-bit unsigned, then zero-extended and added to `Y_OFF` in 10 bits.
  - G = 1 when `v_cnt` equals the trace row.
  - B = 1 when `h_cnt % 64 == 0`, or `v_cnt % 48 == 0`, or `h_cnt == 639`, or `v_cnt == 479`.
  - R = 0.
  - Where trace and grid overlap, both G and B are set.

## Timing
- Reset values:
  - `h_cnt` = `v_cnt` = 0, `front_sel` = 0, FSM = ARM.
  - `hsync` = 1, `vsync` = 1, `rgb` = 0, `busy` = 0, `auto_trig` = 0.
  - Buffer contents are not reset. The first frame after reset may show garbage.
- Read pipeline: counters → synchronous RAM read → compare/register.
  - `hsync`, `vsync` and `rgb` are all delayed by exactly 2 pixel periods (4 clk) relative to the counters.
  - The three outputs are mutually aligned.
- Line period: 1600 clk. Frame period: 840,000 clk.
- `busy` rises in the cycle after the trigger sample and falls in the cycle after the swap.
- Capture-to-display latency: at most one frame after DONE, plus the `hold` duration.
- Reset asserted mid-capture: the capture is abandoned and the FSM returns to ARM. No partial swap occurs.

## Test plan
- Reset then release:
  - `hsync` = `vsync` = 1 and `rgb` = 0 until the first active pixel.
  - `hsync` low for 192 clk of every 1600.
  - `vsync` low for 3200 clk of every 840,000.
- Ramp 0..255 (one sample per 4 clk), `trig_level` = 128:
  - Trigger on sample 128; `auto_trig` = 0.
  - After the swap, column 0 shows G = 1 only at row 239, and column 1 shows G = 1 at row 238.
- Constant 50, `trig_level` = 128:
  - Forced trigger after 65536 valid samples; `auto_trig` = 1.
  - Trace is flat at row 317 across all 640 columns.
- Graticule:
  - B = 1 at (0,y), (64,y), (x,48), (639,y), (x,479).
  - B = 0 at (1,1).
  - `rgb` = 0 during blanking (`h_cnt` = 700).
- `hold` = 1 raised during CAPTURE:
  - FSM stays in DONE across 3 frames; `front_sel` is unchanged.
  - After `hold` falls, the swap occurs exactly at the next `v_cnt` = 480, `h_cnt` = 0.
- `rst_n` pulsed at `wr_addr` = 300:
  - `busy` = 0 immediately and `front_sel` = 0.
  - The next capture starts from address 0 after re-arm.

Source files
------------

// File: rtl/scope_trace_display.sv
// scope_trace_display
// Oscilloscope back end: captures a triggered window of screen-scaled samples
// into a ping-pong trace buffer and draws the front buffer as a one-pixel
// trace over a graticule on a VGA raster. This block is the VGA timing master.
module scope_trace_display #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int Y_OFF    = 112,
  parameter int TIMEOUT  = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_vld,
  input  logic [7:0] trig_level,
  input  logic       hold,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       busy,
  output logic       auto_trig
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(H_ACTIVE);
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EDGE   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_EDGE   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(H_ACTIVE - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [9:0]    Y_BASE    = 10'(Y_OFF);

  // Capture FSM encoding; the upper bit doubles as "buffer owned by capture"
  localparam logic [1:0] ST_ARM     = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Raster timing
  logic          pix_en_q;
  logic          pix_en;
  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;
  logic [5:0]    gv_cnt_q;

  // Read pipeline, stage 1 (after RAM read) and stage 2 (output registers)
  logic          active;
  logic          grid;
  logic          hs_n;
  logic          vs_n;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_q;
  logic          act1_q;
  logic          grid1_q;
  logic [VW-1:0] v1_q;
  logic          hs1_q;
  logic          vs1_q;
  logic [9:0]    trace_row;
  logic          trace_hit;
  logic          hsync_q;
  logic          vsync_q;
  logic [2:0]    rgb_q;

  // Trace buffers and capture state
  logic [7:0]    mem0 [H_ACTIVE];
  logic [7:0]    mem1 [H_ACTIVE];
  logic [1:0]    state_q, state_d;
  logic [7:0]    prev_q, prev_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          front_sel_q, front_sel_d;
  logic          auto_q, auto_d;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          trig_hit;
  logic          swap_pt;

  assign pix_en = pix_en_q;

  // Divide the system clock down to the half-rate pixel enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en_q <= 1'b0;
    end else begin
      pix_en_q <= ~pix_en_q;
    end
  end

  // Horizontal/vertical raster counters plus a row phase counter for the 48-line grid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      gv_cnt_q <= '0;
    end else if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_q <= '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_q  <= '0;
          gv_cnt_q <= '0;
        end else begin
          v_cnt_q  <= v_cnt_q + 1'b1;
          gv_cnt_q <= (gv_cnt_q == 6'd47) ? 6'd0 : gv_cnt_q + 6'd1;
        end
      end else begin
        h_cnt_q <= h_cnt_q + 1'b1;
      end
    end
  end

  // Decode the current raster position into area, grid and sync flags
  always_comb begin
    active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    grid    = (h_cnt_q[5:0] == 6'd0) || (h_cnt_q == H_EDGE) ||
              (gv_cnt_q == 6'd0) || (v_cnt_q == V_EDGE);
    hs_n    = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    vs_n    = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    rd_addr = active ? h_cnt_q[AW-1:0] : '0;
  end

  // Trace buffer write port (capture bank only) and front-bank read port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_sel_q) begin
        mem0[wr_addr] <= sample_in;
      end else begin
        mem1[wr_addr] <= sample_in;
      end
    end
    if (pix_en) begin
      rd_q <= front_sel_q ? mem1[rd_addr] : mem0[rd_addr];
    end
  end

  // Stage 1: carry raster flags alongside the RAM read so they stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act1_q  <= 1'b0;
      grid1_q <= 1'b0;
      v1_q    <= '0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
    end else if (pix_en) begin
      act1_q  <= active;
      grid1_q <= grid;
      v1_q    <= v_cnt_q;
      hs1_q   <= hs_n;
      vs1_q   <= vs_n;
    end
  end

  // Map the stored sample (0 = bottom) to its raster row inside the trace window
  always_comb begin
    trace_row = Y_BASE + {2'b00, 8'd255 - rd_q};
    trace_hit = (10'(v1_q) == trace_row);
  end

  // Stage 2: register colour and sync so all three outputs leave together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 3'b000;
    end else if (pix_en) begin
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
      rgb_q   <= {1'b0, act1_q && trace_hit, act1_q && grid1_q};
    end
  end

  assign trig_hit = (prev_q < trig_level) && (sample_in >= trig_level);
  assign swap_pt  = pix_en && (h_cnt_q == '0) && (v_cnt_q == V_ACT);

  // Capture FSM next state: arm, look for a rising crossing or timeout, fill, wait for swap
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    tmo_d       = tmo_q;
    wr_addr_d   = wr_addr_q;
    front_sel_d = front_sel_q;
    auto_d      = auto_q;
    wr_en       = 1'b0;
    wr_addr     = wr_addr_q;
    case (state_q)
      ST_ARM: begin
        if (sample_vld) begin
          prev_d  = sample_in;
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sample_vld) begin
          prev_d = sample_in;
          if (trig_hit || (tmo_q == TMO_LAST)) begin
            auto_d    = !trig_hit;
            wr_en     = 1'b1;
            wr_addr   = '0;
            wr_addr_d = AW'(1);
            state_d   = ST_CAPTURE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (sample_vld) begin
          wr_en = 1'b1;
          if (wr_addr_q == ADDR_LAST) begin
            state_d = ST_DONE;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      default: begin
        if (swap_pt && !hold) begin
          front_sel_d = !front_sel_q;
          state_d     = ST_ARM;
        end
      end
    endcase
  end

  // Capture FSM state registers; reset abandons any capture in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARM;
      prev_q      <= '0;
      tmo_q       <= '0;
      wr_addr_q   <= '0;
      front_sel_q <= 1'b0;
      auto_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      tmo_q       <= tmo_d;
      wr_addr_q   <= wr_addr_d;
      front_sel_q <= front_sel_d;
      auto_q      <= auto_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign rgb       = rgb_q;
  assign busy      = (state_q == ST_CAPTURE) || (state_q == ST_DONE);
  assign auto_trig = auto_q;

endmodule

// File: tb/tb_scope_trace_display.sv
// tb_scope_trace_display
// Directed bench for scope_trace_display using a shrunken raster so several
// frames fit in a short run. Raster position of each output pixel is tracked
// by counting clock edges since reset release.
module tb_scope_trace_display;

  localparam int HA = 72, HFP = 2, HSY = 4, HBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VA = 24, VFP = 1, VSY = 2, VBP = 1;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int YOFF = 2;
  localparam int TMO = 64;
  localparam int FRAME_CLK = 2 * HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = '0;
  logic       sample_vld = 1'b0;
  logic [7:0] trig_level = '0;
  logic       hold = 1'b0;
  logic       hsync, vsync, busy, auto_trig;
  logic [2:0] rgb;

  int total = 0;
  int bad = 0;
  int ecnt;

  scope_trace_display #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .Y_OFF(YOFF), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_vld(sample_vld),
    .trig_level(trig_level), .hold(hold), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .busy(busy), .auto_trig(auto_trig)
  );

  always #10 clk = ~clk;

  // Edges since reset release; output pixel p is visible while ecnt is 2p+4 or 2p+5
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic goto_pixel(input int x, input int y);
    int p;
    int guard;
    bit found;
    guard = 0;
    found = 0;
    while (!found && guard < 2 * FRAME_CLK) begin
      @(negedge clk);
      guard++;
      if (ecnt >= 4 && (ecnt % 2) == 0) begin
        p = (ecnt - 4) / 2;
        if ((p % HT) == x && ((p / HT) % VT) == y) found = 1;
      end
    end
    if (!found) begin
      total++; bad++;
      $display("[TB] FAIL goto_pixel(%0d,%0d): got timeout want reached", x, y);
    end
  endtask

  task automatic send_sample(input logic [7:0] v);
    @(negedge clk);
    sample_in = v;
    sample_vld = 1'b1;
    @(negedge clk);
    sample_vld = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Waits for busy to fall; returns the raster pixel whose pix_en edge did the swap
  task automatic wait_swap(output int p_fall);
    int guard;
    guard = 0;
    while (busy && guard < 2 * FRAME_CLK) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      total++; bad++;
      $display("[TB] FAIL wait_swap: got busy=1 want swap within 2 frames");
      p_fall = -1;
    end else begin
      p_fall = (ecnt - 2) / 2;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (hsync !== 1'b1) begin bad++; $display("[TB] FAIL reset_hsync: got %b want 1", hsync); end
    total++; if (vsync !== 1'b1) begin bad++; $display("[TB] FAIL reset_vsync: got %b want 1", vsync); end
    total++; if (rgb !== 3'b000) begin bad++; $display("[TB] FAIL reset_rgb: got %b want 000", rgb); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (auto_trig !== 1'b0) begin bad++; $display("[TB] FAIL reset_auto: got %b want 0", auto_trig); end
    rst_n = 1'b1;
  endtask

  task automatic test_sync();
    int hl;
    int vl;
    goto_pixel(73, 0);
    total++; if (hsync !== 1'b1) begin bad++; $display("[TB] FAIL hsync_73: got %b want 1", hsync); end
    goto_pixel(74, 0);
    total++; if (hsync !== 1'b0) begin bad++; $display("[TB] FAIL hsync_74: got %b want 0", hsync); end
    goto_pixel(77, 0);
    total++; if (hsync !== 1'b0) begin bad++; $display("[TB] FAIL hsync_77: got %b want 0", hsync); end
    goto_pixel(78, 0);
    total++; if (hsync !== 1'b1) begin bad++; $display("[TB] FAIL hsync_78: got %b want 1", hsync); end
    goto_pixel(79, 24);
    total++; if (vsync !== 1'b1) begin bad++; $display("[TB] FAIL vsync_24: got %b want 1", vsync); end
    goto_pixel(0, 25);
    total++; if (vsync !== 1'b0) begin bad++; $display("[TB] FAIL vsync_25: got %b want 0", vsync); end
    goto_pixel(79, 26);
    total++; if (vsync !== 1'b0) begin bad++; $display("[TB] FAIL vsync_26: got %b want 0", vsync); end
    goto_pixel(0, 27);
    total++; if (vsync !== 1'b1) begin bad++; $display("[TB] FAIL vsync_27: got %b want 1", vsync); end
    hl = 0;
    vl = 0;
    for (int i = 0; i < FRAME_CLK; i++) begin
      @(negedge clk);
      if (!hsync) hl++;
      if (!vsync) vl++;
    end
    total++; if (hl !== 2 * HSY * VT) begin bad++; $display("[TB] FAIL hsync_low_clk: got %0d want %0d", hl, 2 * HSY * VT); end
    total++; if (vl !== 2 * HT * VSY) begin bad++; $display("[TB] FAIL vsync_low_clk: got %0d want %0d", vl, 2 * HT * VSY); end
  endtask

  task automatic test_ramp();
    int pf;
    trig_level = 8'd240;
    for (int v = 200; v < 240; v++) send_sample(8'(v));
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ramp_pre_busy: got %b want 0", busy); end
    send_sample(8'd240);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ramp_trig_busy: got %b want 1", busy); end
    total++; if (auto_trig !== 1'b0) begin bad++; $display("[TB] FAIL ramp_auto: got %b want 0", auto_trig); end
    for (int k = 1; k < HA; k++) send_sample(8'(240 + k));
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ramp_done_busy: got %b want 1", busy); end
    wait_swap(pf);
    total++;
    if (pf < 0 || (pf % HT) != 0 || ((pf / HT) % VT) != VA) begin
      bad++; $display("[TB] FAIL ramp_swap_pos: got pixel %0d want h=0 v=%0d", pf, VA);
    end
    goto_pixel(15, 2);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL ramp_c15_r2: got G=%b want 1", rgb[1]); end
    goto_pixel(0, 16);
    total++; if (rgb[1] !== 1'b0) begin bad++; $display("[TB] FAIL ramp_c0_r16: got G=%b want 0", rgb[1]); end
    goto_pixel(1, 16);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL ramp_c1_r16: got G=%b want 1", rgb[1]); end
    goto_pixel(0, 17);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL ramp_c0_r17: got G=%b want 1", rgb[1]); end
    goto_pixel(1, 17);
    total++; if (rgb[1] !== 1'b0) begin bad++; $display("[TB] FAIL ramp_c1_r17: got G=%b want 0", rgb[1]); end
  endtask

  task automatic test_graticule();
    goto_pixel(10, 0);
    total++; if (rgb !== 3'b001) begin bad++; $display("[TB] FAIL grid_10_0: got %b want 001", rgb); end
    goto_pixel(1, 1);
    total++; if (rgb !== 3'b000) begin bad++; $display("[TB] FAIL grid_1_1: got %b want 000", rgb); end
    goto_pixel(0, 5);
    total++; if (rgb !== 3'b001) begin bad++; $display("[TB] FAIL grid_0_5: got %b want 001", rgb); end
    goto_pixel(64, 5);
    total++; if (rgb !== 3'b001) begin bad++; $display("[TB] FAIL grid_64_5: got %b want 001", rgb); end
    goto_pixel(71, 5);
    total++; if (rgb !== 3'b001) begin bad++; $display("[TB] FAIL grid_71_5: got %b want 001", rgb); end
    goto_pixel(75, 5);
    total++; if (rgb !== 3'b000) begin bad++; $display("[TB] FAIL blank_h75: got %b want 000", rgb); end
    goto_pixel(10, 23);
    total++; if (rgb !== 3'b001) begin bad++; $display("[TB] FAIL grid_10_23: got %b want 001", rgb); end
    goto_pixel(10, 25);
    total++; if (rgb !== 3'b000) begin bad++; $display("[TB] FAIL blank_v25: got %b want 000", rgb); end
  endtask

  task automatic test_timeout();
    int pf;
    trig_level = 8'd128;
    for (int i = 0; i < TMO; i++) send_sample(8'd250);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL tmo_pre_busy: got %b want 0", busy); end
    send_sample(8'd250);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL tmo_busy: got %b want 1", busy); end
    total++; if (auto_trig !== 1'b1) begin bad++; $display("[TB] FAIL tmo_auto: got %b want 1", auto_trig); end
    for (int k = 1; k < HA; k++) send_sample(8'd250);
    wait_swap(pf);
    total++;
    if (pf < 0 || (pf % HT) != 0 || ((pf / HT) % VT) != VA) begin
      bad++; $display("[TB] FAIL tmo_swap_pos: got pixel %0d want h=0 v=%0d", pf, VA);
    end
    goto_pixel(5, 6);
    total++; if (rgb[1] !== 1'b0) begin bad++; $display("[TB] FAIL flat_c5_r6: got G=%b want 0", rgb[1]); end
    goto_pixel(5, 7);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL flat_c5_r7: got G=%b want 1", rgb[1]); end
    goto_pixel(40, 7);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL flat_c40_r7: got G=%b want 1", rgb[1]); end
    goto_pixel(71, 7);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL flat_c71_r7: got G=%b want 1", rgb[1]); end
    goto_pixel(71, 8);
    total++; if (rgb[1] !== 1'b0) begin bad++; $display("[TB] FAIL flat_c71_r8: got G=%b want 0", rgb[1]); end
  endtask

  task automatic test_hold();
    int pf;
    int pdrop;
    bit stayed;
    trig_level = 8'd236;
    for (int v = 220; v < 236; v++) send_sample(8'(v));
    send_sample(8'd236);
    total++; if (auto_trig !== 1'b0) begin bad++; $display("[TB] FAIL hold_auto: got %b want 0", auto_trig); end
    for (int k = 1; k <= 10; k++) send_sample(8'(236 + k));
    hold = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL hold_cap_busy: got %b want 1", busy); end
    for (int k = 11; k < HA; k++) send_sample(8'(236 + k));
    stayed = 1'b1;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (!busy) stayed = 1'b0;
    end
    total++; if (stayed !== 1'b1) begin bad++; $display("[TB] FAIL hold_3frames: got busy dropped=1 want 0"); end
    goto_pixel(0, 7);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL hold_old_r7: got G=%b want 1", rgb[1]); end
    goto_pixel(0, 21);
    total++; if (rgb[1] !== 1'b0) begin bad++; $display("[TB] FAIL hold_old_r21: got G=%b want 0", rgb[1]); end
    goto_pixel(10, 5);
    pdrop = (ecnt - 4) / 2;
    hold = 1'b0;
    wait_swap(pf);
    total++;
    if (pf <= pdrop || (pf - pdrop) >= HT * VT || (pf % HT) != 0 || ((pf / HT) % VT) != VA) begin
      bad++; $display("[TB] FAIL hold_swap_pos: got pixel %0d want next h=0 v=%0d after %0d", pf, VA, pdrop);
    end
    goto_pixel(0, 7);
    total++; if (rgb[1] !== 1'b0) begin bad++; $display("[TB] FAIL hold_new_r7: got G=%b want 0", rgb[1]); end
    goto_pixel(0, 21);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL hold_new_r21: got G=%b want 1", rgb[1]); end
  endtask

  task automatic test_reset_mid();
    int pf;
    trig_level = 8'd240;
    for (int v = 230; v < 240; v++) send_sample(8'(v));
    send_sample(8'd240);
    for (int k = 1; k < 40; k++) send_sample(8'(240 + k));
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy_before: got %b want 1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy_reset: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    goto_pixel(50, 7);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL mid_front0_c50: got G=%b want 1", rgb[1]); end
    goto_pixel(0, 17);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL mid_front0_c0: got G=%b want 1", rgb[1]); end
    trig_level = 8'd245;
    for (int v = 240; v < 245; v++) send_sample(8'(v));
    send_sample(8'd245);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rearm_busy: got %b want 1", busy); end
    for (int k = 1; k < HA; k++) send_sample(8'(245 + k));
    wait_swap(pf);
    total++;
    if (pf < 0 || (pf % HT) != 0 || ((pf / HT) % VT) != VA) begin
      bad++; $display("[TB] FAIL rearm_swap_pos: got pixel %0d want h=0 v=%0d", pf, VA);
    end
    goto_pixel(0, 11);
    total++; if (rgb[1] !== 1'b0) begin bad++; $display("[TB] FAIL rearm_c0_r11: got G=%b want 0", rgb[1]); end
    goto_pixel(1, 11);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL rearm_c1_r11: got G=%b want 1", rgb[1]); end
    goto_pixel(0, 12);
    total++; if (rgb[1] !== 1'b1) begin bad++; $display("[TB] FAIL rearm_c0_r12: got G=%b want 1", rgb[1]); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_ramp();
    test_graticule();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
